// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding,
// stream framing constants and the header word-count check.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM,
    ST_FIRE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // A count of zero, or more words than the RAM holds, aborts the load.
  function automatic logic hdr_bad(input logic [15:0] n, input int addr_w);
    logic [16:0] cap;
    cap = 17'(1) << addr_w;
    return (n == 16'd0) || ({1'b0, n} > cap);
  endfunction

endpackage

// File: rtl/prog_loader_pack.sv
// Byte lane counter plus little-endian word assembler; word_valid marks the
// cycle in which the 4th byte of a word is accepted, with the full word on word.
module prog_loader_pack
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam int SR_W   = 8 * (BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane_p0;
  logic [SR_W-1:0]   sr_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_p0 <= '0;
    end else if (byte_vld) begin
      lane_p0 <= lane_p0 + LANE_W'(1);
    end
  end

  // Earlier bytes slide down so the first byte of a word lands in bits 7:0.
  always_ff @(posedge clk) begin
    if (byte_vld) begin
      sr_p0 <= {byte_in, sr_p0[SR_W-1:8]};
    end
  end

  assign word       = {byte_in, sr_p0};
  assign word_valid = byte_vld && (lane_p0 == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Load-then-run boot loader for processor_1: header, LE payload words to RAM,
// then release reset with a start pulse. Optional trailing XOR byte: PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              proc_rst,
  output logic              proc_start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = ADDR_W + 1;

  state_t        state_p0, state_nx;
  logic [7:0]    cnt_lo_p0;
  logic [CW-1:0] n_words_p0;
  logic [CW-1:0] wcnt_p0;
  logic [15:0]   hdr_n;
  logic          accept;
  logic          data_byte;
  logic          payload_end;
  logic [31:0]   word;
  logic          word_valid;

  assign hdr_n       = {in_data, cnt_lo_p0};
  assign accept      = in_valid && in_ready;
  assign data_byte   = accept && (state_p0 == ST_DATA);
  assign payload_end = (wcnt_p0 == n_words_p0);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_p0;
  logic       csum_ok;
  assign csum_ok = (in_data == csum_p0);
`endif

  prog_loader_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .byte_vld   (data_byte),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_nx   = state_p0;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    proc_rst   = 1'b1;
    proc_start = 1'b0;
    case (state_p0)
      ST_HDR0: begin
        in_ready = 1'b1;
        if (accept) state_nx = ST_HDR1;
      end
      ST_HDR1: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nx = hdr_bad(hdr_n, ADDR_W) ? ST_ERR : ST_DATA;
      end
      // Once the last word is taken, the strobe cycle passes before leaving
      // DATA so the processor never starts while its RAM is still being written.
      ST_DATA: begin
        in_ready = !payload_end;
        busy     = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        if (payload_end) state_nx = ST_CSUM;
`else
        if (payload_end) state_nx = ST_FIRE;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nx = csum_ok ? ST_FIRE : ST_ERR;
      end
`endif
      ST_FIRE: begin
        busy       = 1'b1;
        proc_rst   = 1'b0;
        proc_start = 1'b1;
        state_nx   = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        proc_rst = 1'b0;
      end
      ST_ERR: begin
        err = 1'b1;
      end
      default: begin
        state_nx = ST_ERR;
      end
    endcase
  end

  // ---- stage p0 -> p1: state, counters and registered RAM write ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= ST_HDR0;
      wcnt_p0    <= '0;
      n_words_p0 <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_p0 <= state_nx;
      mem_we   <= word_valid;
      if (accept && (state_p0 == ST_HDR1)) begin
        n_words_p0 <= CW'(hdr_n);
      end
      if (word_valid) begin
        mem_addr  <= wcnt_p0[ADDR_W-1:0];
        mem_wdata <= word;
        wcnt_p0   <= wcnt_p0 + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && (state_p0 == ST_HDR0)) begin
      cnt_lo_p0 <= in_data;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_p0 <= '0;
    end else if (data_byte) begin
      csum_p0 <= csum_p0 ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as streams
// are built, and a negedge monitor pops and compares on every mem_we.
module tb_prog_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              proc_rst;
  logic              proc_start;
  logic              busy;
  logic              done;
  logic              err;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .proc_rst   (proc_rst),
    .proc_start (proc_start),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        e_w;
  logic [7:0] bq[$];
  logic [7:0] cs;
  logic       prev_we = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         start_cnt = 0;
  int         start_base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next queued write.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h want none", mem_addr, mem_wdata);
      end else begin
        e_w = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e_w.a));
        check("wr_data", mem_wdata, e_w.d);
      end
      check("we_one_cycle", 32'(prev_we), 32'd0);
    end
    if (proc_start) begin
      start_cnt++;
      check("start_after_writes", 32'(exp_q.size()), 32'd0);
      check("start_no_we", 32'(mem_we), 32'd0);
      check("start_rst_low", 32'(proc_rst), 32'd0);
    end
    prev_we = mem_we;
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 50) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got in_ready=0 want byte %h accepted", b);
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < gap; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_q(input int gap);
    while (bq.size() > 0) send_byte(bq.pop_front(), gap);
  endtask

  task automatic hdr(input logic [15:0] n);
    cs = 8'h00;
    bq.push_back(n[7:0]);
    bq.push_back(n[15:8]);
  endtask

  task automatic add_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
    wr_t x;
    for (int i = 0; i < 4; i++) begin
      bq.push_back(w[8*i +: 8]);
      cs = cs ^ w[8*i +: 8];
    end
    x.a = a;
    x.d = w;
    exp_q.push_back(x);
  endtask

  // Sends the queued payload, checks no extra byte is taken, then the checksum if built in.
  task automatic finish_load(input int gap);
    send_q(gap);
    check("post_payload_ready", 32'(in_ready), 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(cs, gap);
`endif
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || err) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!(done || err)) begin
      total++;
      bad++;
      $display("FAIL end_timeout: got done=0 err=0 want one set");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_proc_rst"}, 32'(proc_rst), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_starts"}, 32'(start_cnt - start_base), 32'd1);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_err(input string tag);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_proc_rst"}, 32'(proc_rst), 32'd1);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_starts"}, 32'(start_cnt - start_base), 32'd0);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    do_reset();
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_proc_rst", 32'(proc_rst), 32'd1);
    check("rst_start", 32'(proc_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // N=2, back-to-back bytes
    start_base = start_cnt;
    hdr(16'd2);
    add_word(8'd0, 32'h0000_0013);
    add_word(8'd1, 32'h0010_0093);
    finish_load(0);
    wait_end();
    check_done("n2");

    // Zero word count
    do_reset();
    start_base = start_cnt;
    hdr(16'd0);
    send_q(0);
    wait_end();
    check_err("n0");

    // One word beyond RAM capacity
    do_reset();
    start_base = start_cnt;
    hdr(16'd257);
    send_q(0);
    wait_end();
    check_err("n257");

    // N=2 with in_valid low every other cycle
    do_reset();
    start_base = start_cnt;
    hdr(16'd2);
    add_word(8'd0, 32'h0000_0013);
    add_word(8'd1, 32'h0010_0093);
    finish_load(1);
    wait_end();
    check_done("n2_gap");

    // Reset after 6 payload bytes, then a fresh N=1 load
    do_reset();
    start_base = start_cnt;
    hdr(16'd2);
    add_word(8'd0, 32'h0000_0013);
    bq.push_back(8'h93);
    bq.push_back(8'h00);
    send_q(0);
    @(posedge clk);
    #1;
    check("midload_busy", 32'(busy), 32'd1);
    check("midload_writes_left", 32'(exp_q.size()), 32'd0);
    do_reset();
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_proc_rst", 32'(proc_rst), 32'd1);
    hdr(16'd1);
    add_word(8'd0, 32'hDDCC_BBAA);
    finish_load(0);
    wait_end();
    check_done("n1_after_rst");

    // Full RAM: 256 words, addresses 0..255 without counter wrap
    do_reset();
    start_base = start_cnt;
    hdr(16'd256);
    for (int i = 0; i < 256; i++) begin
      add_word(ADDR_W'(i), {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3});
    end
    finish_load(0);
    wait_end();
    check_done("n256");

    // Reset from DONE puts the processor back into reset
    do_reset();
    check("done_rst_proc_rst", 32'(proc_rst), 32'd1);
    check("done_rst_done", 32'(done), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum 01^02^04^08 = 0F accepted
    do_reset();
    start_base = start_cnt;
    hdr(16'd1);
    add_word(8'd0, 32'h0804_0201);
    send_q(0);
    send_byte(8'h0F, 0);
    wait_end();
    check_done("csum_ok");

    // Wrong checksum aborts after the write, with no start pulse
    do_reset();
    start_base = start_cnt;
    hdr(16'd1);
    add_word(8'd0, 32'h0804_0201);
    send_q(0);
    send_byte(8'h0E, 0);
    wait_end();
    check_err("csum_bad");
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
